// File: rtl/instruction_fetcher_pkg.sv
// Shared types, widths, opcodes and helpers for the instruction fetch front end.
package instruction_fetcher_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int INS_WIDTH  = 32;

   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

   // Fetch sequencing: issue a request, wait for the word, hold it for the Dispatcher.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   typedef logic [1:0] bht_ctr_t;
   localparam bht_ctr_t BHT_RESET = 2'b01;  // weakly not taken

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pred_pc;
      logic                  taken;
   } prediction_t;

   // J-type immediate, sign-extended to the address width.
   function automatic logic [ADDR_WIDTH-1:0] imm_j(input logic [INS_WIDTH-1:0] w);
      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
   endfunction

   // B-type immediate, sign-extended to the address width.
   function automatic logic [ADDR_WIDTH-1:0] imm_b(input logic [INS_WIDTH-1:0] w);
      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   endfunction

   // 2-bit saturating counter step toward the observed outcome.
   function automatic bht_ctr_t sat_update(input bht_ctr_t c, input logic taken);
      if (taken)
         return (c == 2'b11) ? c : c + 2'd1;
      else
         return (c == 2'b00) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/instruction_fetcher_branch_predictor.sv
// Branch history table of 2-bit saturating counters: combinational lookup,
// registered update. A same-cycle lookup of an entry being updated sees the old value.
module branch_predictor
   import instruction_fetcher_pkg::*;
#(
   parameter int INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic [INDEX_BITS-1:0] lookup_idx,
   output logic                  lookup_taken,
   input  logic                  update_en,
   input  logic [INDEX_BITS-1:0] update_idx,
   input  logic                  update_taken
);

   localparam int DEPTH = 1 << INDEX_BITS;

   bht_ctr_t bht [DEPTH];

   // Counter array: reset every entry, then train on committed branches.
   // NOTE: the table is built from flops, so every entry is reset explicitly;
   // a RAM-backed table would need a clearing sequence instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bht[i] <= BHT_RESET;
         end
      end else if (rdy && update_en) begin
         // NOTE: non-blocking assignment keeps the lookup port reading the
         // pre-update counter for the whole cycle.
         bht[update_idx] <= sat_update(bht[update_idx], update_taken);
      end
   end

   assign lookup_taken = bht[lookup_idx][1];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch front end: keeps the fetch PC, talks to the icache, predicts the next PC
// and hands one instruction per request to the Dispatcher. A ROB mispredict
// redirects the PC and drops any in-flight request or buffered word.
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int                    BHT_INDEX_BITS = 6,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  enable_from_dispatcher,
   output logic                  enable_to_dispatcher,
   output logic [ADDR_WIDTH-1:0] pc_to_dispatcher,
   output logic [INS_WIDTH-1:0]  ins_to_dispatcher,
   output logic [ADDR_WIDTH-1:0] pred_pc_to_dispatcher,
   output logic                  predict_jump_to_dispatcher,
   output logic                  enable_to_icache,
   output logic [ADDR_WIDTH-1:0] pc_to_icache,
   input  logic                  ready_from_icache,
   input  logic [INS_WIDTH-1:0]  ins_from_icache,
   input  logic                  mispredict,
   input  logic [ADDR_WIDTH-1:0] correct_pc,
   input  logic                  enable_bp_update,
   input  logic [ADDR_WIDTH-1:0] bp_update_pc,
   input  logic                  bp_update_taken
);

   fetch_state_t          state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [INS_WIDTH-1:0]  buf_ins;
   prediction_t           buf_pred;
   prediction_t           pred;
   logic                  bht_taken;

   // Only the index bits of a committed branch PC select a counter.
   logic unused_update_bits;
   assign unused_update_bits = ^{bp_update_pc[ADDR_WIDTH-1:BHT_INDEX_BITS+2], bp_update_pc[1:0]};

   branch_predictor #(
      .INDEX_BITS(BHT_INDEX_BITS)
   ) u_bp (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .lookup_idx  (pc[BHT_INDEX_BITS+1:2]),
      .lookup_taken(bht_taken),
      .update_en   (enable_bp_update),
      .update_idx  (bp_update_pc[BHT_INDEX_BITS+1:2]),
      .update_taken(bp_update_taken)
   );

   // Next-PC prediction for the word arriving from the icache at the current PC.
   always_comb begin
      // NOTE: default both fields first so no path through the case infers a latch.
      pred.pred_pc = pc + 32'd4;
      pred.taken   = 1'b0;
      unique case (ins_from_icache[6:0])
         OPCODE_JAL: begin
            pred.pred_pc = pc + imm_j(ins_from_icache);
            pred.taken   = 1'b1;
         end
         OPCODE_BRANCH: begin
            if (bht_taken) begin
               pred.pred_pc = pc + imm_b(ins_from_icache);
               pred.taken   = 1'b1;
            end
         end
         OPCODE_JALR: begin
            // Indirect target unknown here; fall through sequentially.
         end
         default: begin
         end
      endcase
   end

   // Fetch FSM, PC, instruction buffer and both handshakes; rdy low freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                      <= ST_FETCH;
         pc                         <= RESET_PC;
         buf_ins                    <= '0;
         buf_pred                   <= '0;
         enable_to_dispatcher       <= 1'b0;
         pc_to_dispatcher           <= '0;
         ins_to_dispatcher          <= '0;
         pred_pc_to_dispatcher      <= '0;
         predict_jump_to_dispatcher <= 1'b0;
         enable_to_icache           <= 1'b0;
         pc_to_icache               <= '0;
      end else if (rdy) begin
         enable_to_dispatcher <= 1'b0;
         if (mispredict) begin
            // Returning to FETCH marks the buffer empty; a same-cycle icache word is dropped.
            pc               <= correct_pc;
            enable_to_icache <= 1'b0;
            state            <= ST_FETCH;
         end else begin
            unique case (state)
               ST_FETCH: begin
                  enable_to_icache <= 1'b1;
                  pc_to_icache     <= pc;
                  state            <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (ready_from_icache) begin
                     enable_to_icache <= 1'b0;
                     buf_ins          <= ins_from_icache;
                     buf_pred         <= pred;
                     state            <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  // The request level lags our pulse by a cycle, so ignore it while the pulse is up.
                  if (enable_from_dispatcher && !enable_to_dispatcher) begin
                     enable_to_dispatcher       <= 1'b1;
                     pc_to_dispatcher           <= pc;
                     ins_to_dispatcher          <= buf_ins;
                     pred_pc_to_dispatcher      <= buf_pred.pred_pc;
                     predict_jump_to_dispatcher <= buf_pred.taken;
                     pc                         <= buf_pred.pred_pc;
                     state                      <= ST_FETCH;
                  end
               end
               default: state <= ST_FETCH;
            endcase
         end
      end
   end

endmodule
